// File: rtl/laser_job_sequencer.sv
// Job sequencer for the LASER two-circle core.
// Buffers a point set, feeds the core, watches DONE, returns the result.
//
// Ports:
//   CLK, RST                  clock; async active-high reset
//   IN_VALID/IN_READY/IN_X/Y  host point stream (valid/ready)
//   CORE_RST, CORE_X/Y        core reset and point presented to the core
//   CORE_DONE, CORE_C         core completion and {C2Y,C2X,C1Y,C1X}
//   RES_VALID/RES_READY       result handshake
//   RES_C, RES_TIMEOUT        latched result; watchdog abort flag
//   BUSY                      job in KICK, FEED or WAIT
module laser_job_sequencer #(
  parameter int unsigned NPTS    = 40,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [3:0]  IN_X,
  input  logic [3:0]  IN_Y,
  output logic        CORE_RST,
  output logic [3:0]  CORE_X,
  output logic [3:0]  CORE_Y,
  input  logic        CORE_DONE,
  input  logic [15:0] CORE_C,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [15:0] RES_C,
  output logic        RES_TIMEOUT,
  output logic        BUSY
);

  localparam int CW = $clog2(NPTS + 1);
  localparam int FW = $clog2(NPTS);
  localparam logic [CW-1:0] CNT_FULL  = CW'(NPTS);
  localparam logic [FW-1:0] FEED_LAST = FW'(NPTS - 1);
  localparam logic [15:0]   WD_LAST   = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_KICK,
    S_FEED,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [FW-1:0] fidx_q, fidx_d;
  logic [15:0]   wd_q, wd_d;
  logic [15:0]   res_c_q, res_c_d;
  logic          res_to_q, res_to_d;
  logic [7:0]    pbuf_q [NPTS];

  logic in_state_ok;
  logic feeding;
  logic accept;

  // Output decode only from the state flops so CORE_RST cannot glitch.
  always_comb begin
    in_state_ok = 1'b0;
    feeding     = 1'b0;
    CORE_RST    = 1'b1;
    BUSY        = 1'b0;
    RES_VALID   = 1'b0;
    unique case (state_q)
      S_LOAD: in_state_ok = 1'b1;
      S_KICK: BUSY = 1'b1;
      S_FEED: begin
        CORE_RST = 1'b0;
        BUSY     = 1'b1;
        feeding  = 1'b1;
      end
      S_WAIT: begin
        CORE_RST    = 1'b0;
        BUSY        = 1'b1;
        in_state_ok = 1'b1;
      end
      S_REPORT: begin
        RES_VALID   = 1'b1;
        in_state_ok = 1'b1;
      end
      default: ;
    endcase
  end

  assign IN_READY    = in_state_ok && (count_q < CNT_FULL);
  assign accept      = IN_VALID && IN_READY;
  assign {CORE_Y, CORE_X} = feeding ? pbuf_q[fidx_q] : 8'h00;
  assign RES_C       = res_c_q;
  assign RES_TIMEOUT = res_to_q;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    fidx_d   = fidx_q;
    wd_d     = wd_q;
    res_c_d  = res_c_q;
    res_to_d = res_to_q;
    if (accept) count_d = count_q + 1'b1;
    unique case (state_q)
      // Use the post-accept count so KICK follows the last point directly.
      S_LOAD: if (count_d == CNT_FULL) state_d = S_KICK;
      S_KICK: begin
        state_d = S_FEED;
        fidx_d  = '0;
      end
      S_FEED: begin
        if (fidx_q == FEED_LAST) begin
          state_d = S_WAIT;
          count_d = '0;
          wd_d    = '0;
        end else begin
          fidx_d = fidx_q + 1'b1;
        end
      end
      S_WAIT: begin
        wd_d = wd_q + 16'd1;
        if (CORE_DONE) begin
          state_d  = S_REPORT;
          res_c_d  = CORE_C;
          res_to_d = 1'b0;
        end else if (wd_q == WD_LAST) begin
          state_d  = S_REPORT;
          res_c_d  = '0;
          res_to_d = 1'b1;
        end
      end
      S_REPORT: begin
        // A point landing on the handshake cycle is seen by LOAD next.
        if (RES_READY)
          state_d = (count_q == CNT_FULL) ? S_KICK : S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_LOAD;
      count_q  <= '0;
      fidx_q   <= '0;
      wd_q     <= '0;
      res_c_q  <= '0;
      res_to_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      fidx_q   <= fidx_d;
      wd_q     <= wd_d;
      res_c_q  <= res_c_d;
      res_to_q <= res_to_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) pbuf_q[count_q[FW-1:0]] <= {IN_Y, IN_X};
  end

endmodule

// File: tb/tb_laser_job_sequencer.sv
// Directed bench for laser_job_sequencer.
// The bench plays the core: it drives CORE_DONE/CORE_C itself.
module tb_laser_job_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_x = '0;
  logic [3:0]  in_y = '0;
  logic        core_rst;
  logic [3:0]  core_x;
  logic [3:0]  core_y;
  logic        core_done = 1'b0;
  logic [15:0] core_c = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_c;
  logic        res_to;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [3:0] px [40];
  logic [3:0] py [40];

  laser_job_sequencer #(.NPTS(40), .TIMEOUT(16)) dut (
    .CLK(clk), .RST(rst),
    .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_X(in_x), .IN_Y(in_y),
    .CORE_RST(core_rst), .CORE_X(core_x), .CORE_Y(core_y),
    .CORE_DONE(core_done), .CORE_C(core_c),
    .RES_VALID(res_valid), .RES_READY(res_ready),
    .RES_C(res_c), .RES_TIMEOUT(res_to), .BUSY(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int n);
    repeat (n) tick();
  endtask

  task automatic fill(input int mode);
    for (int k = 0; k < 40; k++) begin
      case (mode)
        0: begin px[k] = 4'd5; py[k] = 4'd5; end
        1: begin px[k] = 4'(k); py[k] = 4'(k * 3 + 1); end
        default: begin px[k] = 4'(15 - k); py[k] = 4'(k * 7 + 2); end
      endcase
    end
  endtask

  // Sends points 0..npts-1; n = accepted, cyc = cycles spent.
  task automatic send_points(input bit gaps, input int npts,
                             output int n, output int cyc);
    bit ph = 1'b0;
    bit acc;
    n = 0;
    cyc = 0;
    while (n < npts && cyc < 2000) begin
      in_valid = gaps ? ph : 1'b1;
      ph = ~ph;
      in_x = px[n];
      in_y = py[n];
      acc = in_valid && in_ready;
      tick();
      if (acc) n++;
      cyc++;
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_job(input logic [15:0] c);
    core_c = c;
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if (in_ready !== 1'b1 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctl got rdy=%b crst=%b want 1 1", in_ready, core_rst);
    end
    checks++;
    if ({core_x, core_y} !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_core got xy=%h busy=%b want 00 0", {core_x, core_y}, busy);
    end
    checks++;
    if (res_valid !== 1'b0 || res_c !== 16'h0 || res_to !== 1'b0) begin
      errors++;
      $display("FAIL reset_res got v=%b c=%h to=%b want 0 0000 0", res_valid, res_c, res_to);
    end
    skip(2);
    rst = 1'b0;
  endtask

  task automatic test_single_job();
    int n, cyc, vcnt;
    fill(0);
    send_points(1'b0, 40, n, cyc);
    checks++;
    if (n !== 40 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_send got n=%0d busy=%b want 40 1", n, busy);
    end
    skip(41);
    checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_wait got busy=%b v=%b want 1 0", busy, res_valid);
    end
    skip(2);
    finish_job(16'h1515);
    checks++;
    if (res_valid !== 1'b1 || res_c !== 16'h1515 || res_to !== 1'b0) begin
      errors++;
      $display("FAIL single_res got v=%b c=%h to=%b want 1 1515 0", res_valid, res_c, res_to);
    end
    handshake();
    vcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid) vcnt++;
      tick();
    end
    checks++;
    if (vcnt !== 0 || in_ready !== 1'b1 || core_rst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_after got extra=%0d rdy=%b crst=%b busy=%b want 0 1 1 0",
               vcnt, in_ready, core_rst, busy);
    end
  endtask

  task automatic test_feed_timing();
    int n, cyc, low, bad;
    fill(1);
    send_points(1'b0, 40, n, cyc);
    checks++;
    if (in_ready !== 1'b0 || core_rst !== 1'b1 || core_x !== 4'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL kick_state got rdy=%b crst=%b x=%h busy=%b want 0 1 0 1",
               in_ready, core_rst, core_x, busy);
    end
    low = 0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (core_rst === 1'b0) low++;
      if (core_x !== px[k] || core_y !== py[k] || in_ready !== 1'b0 || busy !== 1'b1) bad++;
      core_done = (k >= 5 && k < 8);
    end
    core_done = 1'b0;
    tick();
    checks++;
    if (low !== 40 || bad !== 0) begin
      errors++;
      $display("FAIL feed_cycles got low=%0d bad=%0d want 40 0", low, bad);
    end
    checks++;
    if (core_rst !== 1'b0 || core_x !== 4'd0 || in_ready !== 1'b1 || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL wait_entry got crst=%b x=%h rdy=%b v=%b want 0 0 1 0",
               core_rst, core_x, in_ready, res_valid);
    end
    finish_job(16'hA5C3);
    checks++;
    if (res_c !== 16'hA5C3 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL feed_res got c=%h crst=%b want a5c3 1", res_c, core_rst);
    end
    handshake();
  endtask

  task automatic test_timeout();
    int n, cyc, early;
    fill(1);
    send_points(1'b0, 40, n, cyc);
    skip(41);
    early = 0;
    for (int w = 0; w < 16; w++) begin
      if (res_valid !== 1'b0 || busy !== 1'b1) early++;
      tick();
    end
    checks++;
    if (early !== 0) begin
      errors++;
      $display("FAIL timeout_early got %0d bad wait cycles want 0", early);
    end
    checks++;
    if (res_valid !== 1'b1 || res_to !== 1'b1 || res_c !== 16'h0) begin
      errors++;
      $display("FAIL timeout_res got v=%b to=%b c=%h want 1 1 0000", res_valid, res_to, res_c);
    end
    handshake();
  endtask

  task automatic test_done_wins();
    int n, cyc;
    fill(2);
    send_points(1'b0, 40, n, cyc);
    skip(41 + 15);
    checks++;
    if (res_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_wins_pre got v=%b want 0", res_valid);
    end
    finish_job(16'h7E81);
    checks++;
    if (res_valid !== 1'b1 || res_to !== 1'b0 || res_c !== 16'h7E81) begin
      errors++;
      $display("FAIL done_wins got v=%b to=%b c=%h want 1 0 7e81", res_valid, res_to, res_c);
    end
    handshake();
  endtask

  task automatic test_gaps();
    int n, cyc, bad;
    fill(2);
    send_points(1'b1, 40, n, cyc);
    checks++;
    if (n !== 40 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gaps_send got n=%0d busy=%b want 40 1", n, busy);
    end
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (core_x !== px[k] || core_y !== py[k]) bad++;
    end
    tick();
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL gaps_order got %0d wrong points want 0", bad);
    end
    finish_job(16'h5A5A);
    checks++;
    if (res_c !== 16'h5A5A || res_to !== 1'b0) begin
      errors++;
      $display("FAIL gaps_res got c=%h to=%b want 5a5a 0", res_c, res_to);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int n, cyc, j, hold_bad, bad;
    bit acc;
    fill(1);
    send_points(1'b0, 40, n, cyc);
    skip(41);
    finish_job(16'h3C3C);
    fill(2);
    j = 0;
    hold_bad = 0;
    for (int c = 0; c < 100; c++) begin
      if (res_valid !== 1'b1 || res_c !== 16'h3C3C || res_to !== 1'b0) hold_bad++;
      in_valid = (j < 40);
      if (j < 40) begin
        in_x = px[j];
        in_y = py[j];
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) j++;
    end
    in_valid = 1'b0;
    checks++;
    if (hold_bad !== 0 || j !== 40) begin
      errors++;
      $display("FAIL b2b_hold got bad=%0d accepted=%0d want 0 40", hold_bad, j);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full got rdy=%b want 0", in_ready);
    end
    handshake();
    checks++;
    if (busy !== 1'b1 || res_valid !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL b2b_kick got busy=%b v=%b crst=%b want 1 0 1", busy, res_valid, core_rst);
    end
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (core_rst !== 1'b0 || core_x !== px[k] || core_y !== py[k]) bad++;
    end
    tick();
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL b2b_feed got %0d wrong points want 0", bad);
    end
    finish_job(16'hC001);
    handshake();
  endtask

  task automatic test_report_boundary();
    int n, cyc;
    fill(1);
    send_points(1'b0, 40, n, cyc);
    skip(41);
    finish_job(16'h0F0F);
    send_points(1'b0, 39, n, cyc);
    checks++;
    if (n !== 39 || in_ready !== 1'b1 || res_valid !== 1'b1) begin
      errors++;
      $display("FAIL bnd_prefetch got n=%0d rdy=%b v=%b want 39 1 1", n, in_ready, res_valid);
    end
    in_valid = 1'b1;
    in_x = px[39];
    in_y = py[39];
    res_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    res_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || in_ready !== 1'b0 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL bnd_load got busy=%b v=%b rdy=%b crst=%b want 0 0 0 1",
               busy, res_valid, in_ready, core_rst);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || core_rst !== 1'b1) begin
      errors++;
      $display("FAIL bnd_kick got busy=%b crst=%b want 1 1", busy, core_rst);
    end
    tick();
    checks++;
    if (core_rst !== 1'b0 || core_x !== px[0] || core_y !== py[0]) begin
      errors++;
      $display("FAIL bnd_feed0 got crst=%b xy=%h%h want 0 %h%h",
               core_rst, core_x, core_y, px[0], py[0]);
    end
    skip(40);
    finish_job(16'h2222);
    handshake();
  endtask

  task automatic test_reset_midjob();
    int n, cyc, bad;
    fill(1);
    send_points(1'b0, 40, n, cyc);
    skip(21);
    checks++;
    if (core_rst !== 1'b0 || core_x !== px[20]) begin
      errors++;
      $display("FAIL mid_feed20 got crst=%b x=%h want 0 %h", core_rst, core_x, px[20]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (core_rst !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || core_x !== 4'd0) begin
      errors++;
      $display("FAIL mid_rst got crst=%b rdy=%b busy=%b x=%h want 1 1 0 0",
               core_rst, in_ready, busy, core_x);
    end
    tick();
    rst = 1'b0;
    fill(2);
    send_points(1'b0, 40, n, cyc);
    checks++;
    if (n !== 40 || cyc !== 40 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_resend got n=%0d cyc=%0d busy=%b want 40 40 1", n, cyc, busy);
    end
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (core_x !== px[k] || core_y !== py[k]) bad++;
    end
    tick();
    finish_job(16'h1234);
    checks++;
    if (bad !== 0 || res_c !== 16'h1234 || res_to !== 1'b0) begin
      errors++;
      $display("FAIL mid_job got bad=%0d c=%h to=%b want 0 1234 0", bad, res_c, res_to);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_feed_timing();
    test_timeout();
    test_done_wins();
    test_gaps();
    test_back_to_back();
    test_report_boundary();
    test_reset_midjob();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

endmodule
